// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and default sizing for the serial frame sequencer.
package shift_seq_ctrl_pkg;
  localparam int DEF_WIDTH   = 9;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/serializer-control bundle between a frame client and shift_seq_ctrl.
interface shift_seq_ctrl_if
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             Start;
  logic [WIDTH-1:0] Data_In;
  logic             Abort;
  logic             Reg_Msb;
  logic             Load;
  logic             Shift_En;
  logic [WIDTH-1:0] D;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic             Sdo;
  logic             Sclk;

  modport master (
    output Start, Data_In, Abort, Reg_Msb,
    input  Load, Shift_En, D, Ready, Busy, Done, Sdo, Sclk
  );

  modport slave (
    input  Start, Data_In, Abort, Reg_Msb,
    output Load, Shift_En, D, Ready, Busy, Done, Sdo, Sclk
  );
endinterface

// File: rtl/shift_seq_ctrl_clk_div_cnt.sv
// Serial bit-period divider: counts 0..CLK_DIV-1, flags the last count and the
// last count of the low half so the caller can register Sclk edges.
module clk_div_cnt #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic half_tc
);
  localparam int            CW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc      = (cnt_q == LAST);
  assign half_tc = (cnt_q == HALF_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame sequencer driving an external parallel-load / left-shift register:
// one LOAD strobe, then WIDTH bits MSB first, each CLK_DIV clocks long.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             Clk,
  input  logic             Reset_n,
  shift_seq_ctrl_if.slave  bus
);
  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             in_shift, last_bit, div_clr, div_tc, div_half_tc;

  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = (bit_q == BIT_LAST);
  assign div_clr  = !in_shift || bus.Abort;

  clk_div_cnt #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clr     (div_clr),
    .en      (in_shift),
    .tc      (div_tc),
    .half_tc (div_half_tc)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bit_d   = '0;
    sclk_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.Start) begin
        hold_d  = bus.Data_In;
        state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        bit_d  = bit_q;
        sclk_d = sclk_q | div_half_tc;
        if (div_tc) begin
          sclk_d = 1'b0;
          if (last_bit) state_d = ST_DONE;
          else          bit_d   = bit_q + BW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything, including a Start seen in IDLE.
    if (bus.Abort) begin
      state_d = ST_IDLE;
      hold_d  = hold_q;
      bit_d   = '0;
      sclk_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
    end
  end

  // Strobes are masked by Abort so a cancelled frame never touches the register.
  assign bus.Load     = (state_q == ST_LOAD) && !bus.Abort;
  assign bus.Shift_En = in_shift && div_tc && !last_bit && !bus.Abort;
  assign bus.Done     = (state_q == ST_DONE) && !bus.Abort;
  assign bus.Ready    = (state_q == ST_IDLE);
  assign bus.Busy     = (state_q == ST_LOAD) || in_shift;
  assign bus.D        = hold_q;
  assign bus.Sdo      = bus.Reg_Msb;
  assign bus.Sclk     = sclk_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench pairing shift_seq_ctrl with a behavioural shift register; expected
// per-cycle outputs come from a frame-timing model indexed by cycle offset.
module tb_shift_seq_ctrl;
  import shift_seq_ctrl_pkg::*;

  localparam int W   = DEF_WIDTH;
  localparam int DIV = DEF_CLK_DIV;
  localparam int FL  = 2 + W * DIV;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sreg;
  int           n_chk = 0;
  int           n_pass = 0;

  shift_seq_ctrl_if #(.WIDTH(W)) bus ();

  shift_seq_ctrl #(.WIDTH(W), .CLK_DIV(DIV)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            sreg <= '0;
    else if (bus.Load)     sreg <= bus.D;
    else if (bus.Shift_En) sreg <= {sreg[W-2:0], 1'b0};
  end
  assign bus.Reg_Msb = sreg[W-1];

  // Expected outputs t cycles after the accept cycle (t<=0 or past the frame = idle).
  // {sdo_valid, Load, Shift_En, Ready, Busy, Done, Sclk, Sdo}
  function automatic logic [7:0] model(input int t, input logic [W-1:0] d);
    int k, c;
    logic [7:0] e;
    e = 8'b0001_0000;
    if (t == 1) e = 8'b0100_1000;
    else if (t >= 2 && t < FL) begin
      k = (t - 2) / DIV;
      c = (t - 2) % DIV;
      e = {1'b1, 1'b0, (c == DIV - 1 && k < W - 1), 1'b0, 1'b1, 1'b0, (c >= DIV / 2), d[W-1-k]};
    end else if (t == FL) e = 8'b0000_0100;
    return e;
  endfunction

  function automatic logic [6:0] obs();
    return {bus.Load, bus.Shift_En, bus.Ready, bus.Busy, bus.Done, bus.Sclk, bus.Sdo};
  endfunction

  task automatic accept(input logic [W-1:0] d);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Data_In = d;
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.Data_In = '0;
    rst_n = 1'b0;
    #2;
    o = obs();
    n_chk++;
    if (o[6:1] !== 6'b001000) $display("FAIL reset_outs got %b want %b", o[6:1], 6'b001000);
    else n_pass++;
    n_chk++;
    if (bus.D !== '0) $display("FAIL reset_d got %h want 0", bus.D);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic(input logic [W-1:0] d, input string nm);
    logic [7:0] e;
    logic [6:0] o, m;
    logic [W-1:0] bits;
    int shifts, done_t;
    shifts = 0; done_t = -1; bits = '0;
    accept(d);
    for (int t = 1; t <= FL + 1; t++) begin
      @(negedge clk);
      e = model(t, d); o = obs(); m = {6'h3F, e[7]};
      if (bus.Shift_En) shifts++;
      if (bus.Done) done_t = t;
      if (e[7] && ((t - 2) % DIV == 0)) bits[W-1-(t-2)/DIV] = bus.Sdo;
      n_chk++;
      if ((o & m) !== (e[6:0] & m)) $display("FAIL %s t=%0d got %b want %b", nm, t, o, e[6:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (shifts !== W - 1) $display("FAIL %s_shift_cnt got %0d want %0d", nm, shifts, W - 1);
    else n_pass++;
    n_chk++;
    if (done_t !== FL) $display("FAIL %s_done_cycle got %0d want %0d", nm, done_t, FL);
    else n_pass++;
    n_chk++;
    if (bits !== d) $display("FAIL %s_serial got %h want %h", nm, bits, d);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = W'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      test_basic(d, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [6:0] o, m;
    int dones;
    dones = 0;
    @(negedge clk);
    bus.Start = 1'b1; bus.Data_In = 9'h1FF;
    @(posedge clk); #1;
    bus.Data_In = 9'h000;
    for (int t = 1; t <= 2 * FL + 3; t++) begin
      if (t == FL + 2) bus.Start = 1'b0;
      @(negedge clk);
      e = (t <= FL) ? model(t, 9'h1FF) : model(t - (FL + 1), 9'h000);
      o = obs(); m = {6'h3F, e[7]};
      if (bus.Done) dones++;
      n_chk++;
      if ((o & m) !== (e[6:0] & m)) $display("FAIL b2b t=%0d got %b want %b", t, o, e[6:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (dones !== 2) $display("FAIL b2b_done_cnt got %0d want 2", dones);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] e;
    logic [6:0] o, m;
    logic [W-1:0] d;
    d = W'($urandom);
    accept(d);
    for (int t = 1; t <= 24; t++) begin
      bus.Abort = (t == 15);
      @(negedge clk);
      e = model((t >= 16) ? 0 : t, d); o = obs(); m = {6'h3F, e[7]};
      n_chk++;
      if ((o & m) !== (e[6:0] & m)) $display("FAIL abort t=%0d got %b want %b", t, o, e[6:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    // Abort together with Start in IDLE: frame must not be accepted.
    @(negedge clk);
    bus.Start = 1'b1; bus.Abort = 1'b1; bus.Data_In = ~d;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Abort = 1'b0;
    @(negedge clk);
    o = obs();
    n_chk++;
    if (o[6:1] !== 6'b001000) $display("FAIL abort_start got %b want %b", o[6:1], 6'b001000);
    else n_pass++;
    n_chk++;
    if (bus.D !== d) $display("FAIL abort_start_hold got %h want %h", bus.D, d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    logic [6:0] o, m;
    logic [W-1:0] d;
    d = W'($urandom) | W'(1);
    accept(d);
    for (int t = 1; t < 20; t++) begin
      @(negedge clk);
      e = model(t, d); o = obs(); m = {6'h3F, e[7]};
      n_chk++;
      if ((o & m) !== (e[6:0] & m)) $display("FAIL rst_mid t=%0d got %b want %b", t, o, e[6:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    o = obs();
    n_chk++;
    if ({o, bus.D} !== {7'b0010000, W'(0)}) $display("FAIL rst_mid_async got %b/%h want %b/0", o, bus.D, 7'b0010000);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      o = obs();
      n_chk++;
      if (o[6:1] !== 6'b001000) $display("FAIL rst_mid_idle c=%0d got %b want %b", t, o[6:1], 6'b001000);
      else n_pass++;
    end
    test_basic(W'($urandom), "post_rst");
  endtask

  task automatic test_busy_start();
    logic [7:0] e;
    logic [6:0] o, m;
    logic [W-1:0] d;
    d = W'($urandom);
    accept(d);
    for (int t = 1; t <= FL + 1; t++) begin
      bus.Start = (t == 5 || t == 10);
      bus.Data_In = ~d;
      @(negedge clk);
      e = model(t, d); o = obs(); m = {6'h3F, e[7]};
      n_chk++;
      if ((o & m) !== (e[6:0] & m)) $display("FAIL busy_start t=%0d got %b want %b", t, o, e[6:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.Start = 1'b0;
    n_chk++;
    if (bus.D !== d) $display("FAIL busy_start_hold got %h want %h", bus.D, d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic(9'h1A5, "basic");
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_busy_start();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
